// File: rtl/program_loader.sv
// Boot-time program loader: assembles a length-prefixed, XOR-checksummed byte stream into
// 32-bit instruction words, writes them from address 0 and holds the CPU in reset until verified.
module program_loader #(
  parameter int ADDR_W = 10,
  parameter int WORDS  = 1024
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [7:0]        Rx_Data,
  input  logic              Rx_Valid,
  output logic              Rx_Ready,
  output logic              IMem_WrEn,
  output logic [ADDR_W-1:0] IMem_Addr,
  output logic [31:0]       IMem_WrData,
  output logic              Cpu_Reset,
  output logic              Load_Done,
  output logic              Error
);

  localparam logic [16:0] WORDS_L = 17'(WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        word_idx_q, word_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        word_q, word_d;
  logic [7:0]         csum_q, csum_d;
  logic               rx_ready_q, rx_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               take;
  logic [15:0]        n_hdr;

  // Rx_Ready is registered from the next state, so it always mirrors state_q.
  assign take  = Rx_Valid & rx_ready_q;
  assign n_hdr = {cnt_q[15:8], Rx_Data};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    csum_d      = csum_q;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: state_d = S_HDR0;
      S_HDR0: begin
        if (take) begin
          cnt_d[15:8] = Rx_Data;
          state_d     = S_HDR1;
        end
      end
      S_HDR1: begin
        if (take) begin
          cnt_d = n_hdr;
          if ({1'b0, n_hdr} > WORDS_L) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n_hdr == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (take) begin
          word_d     = {word_q[15:0], Rx_Data};
          csum_d     = csum_q ^ Rx_Data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_data_d  = {word_q, Rx_Data};
            addr_d     = word_idx_q[ADDR_W-1:0];
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == cnt_q - 16'd1) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (take) begin
          if (csum_q == Rx_Data) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    rx_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                 (state_d == S_DATA) || (state_d == S_CSUM);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      rx_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      rx_ready_q  <= rx_ready_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign Rx_Ready    = rx_ready_q;
  assign IMem_WrEn   = wr_en_q;
  assign IMem_Addr   = addr_q;
  assign IMem_WrData = wr_data_q;
  assign Cpu_Reset   = cpu_reset_q;
  assign Load_Done   = done_q;
  assign Error       = err_q;

endmodule
